// File: rtl/sigmon_event_drain_if.sv
// Output stream of the sigmon event drain: one 36-bit record per transfer,
// tagged with its source monitor, a burst-end marker and a valid/ready handshake.
interface sigmon_event_drain_if #(
   parameter int SRC_W = 2
);
   logic [35:0]      tdata;
   logic [SRC_W-1:0] tsrc;
   logic             tlast;
   logic             tvalid;
   logic             tready;

   modport master (output tdata, tsrc, tlast, tvalid, input tready);
   modport slave  (input tdata, tsrc, tlast, tvalid, output tready);
endinterface

// File: rtl/sigmon_event_drain.sv
// Round-robin drain of N_MON event-monitor FIFOs into one tagged 36-bit stream,
// with a single read in flight, sticky underflow/format errors and a word counter.
module sigmon_event_drain #(
   parameter int N_MON     = 4,
   parameter int SRC_W     = 2,
   parameter int BURST_LEN = 16,
   parameter int TIMEOUT   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  drain_enable,
   input  logic [N_MON*36-1:0]   mon_data_out,
   input  logic [N_MON*11-1:0]   mon_data_count,
   input  logic [N_MON-1:0]      mon_data_valid,
   input  logic [N_MON-1:0]      mon_data_loss,
   output logic [N_MON-1:0]      mon_data_read,
   sigmon_event_drain_if.master  m_axis,
   output logic                  loss_any,
   output logic                  err_underflow,
   output logic                  err_format,
   output logic [31:0]           words_drained
);

   localparam int BC_W  = $clog2(BURST_LEN) + 1;
   localparam int TMO_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {IDLE, ARB, RD, WAIT_V, HOLD} state_t;

   state_t           state_q;
   logic [SRC_W-1:0] ptr_q;
   logic [SRC_W-1:0] grant_q;
   logic [BC_W-1:0]  burst_cnt_q;
   logic [TMO_W-1:0] tmo_q;
   logic [35:0]      tdata_q;
   logic [SRC_W-1:0] tsrc_q;
   logic             tlast_q;
   logic             tvalid_q;
   logic             en_q;
   logic             loss_any_q;
   logic             err_underflow_q;
   logic             err_format_q;
   logic [31:0]      words_q;

   logic [35:0]      mon_word [N_MON];
   logic [10:0]      mon_cnt  [N_MON];
   logic             scan_hit;
   logic [SRC_W-1:0] scan_idx;
   logic [SRC_W-1:0] next_ptr;
   logic [35:0]      gnt_word;
   logic [10:0]      gnt_count;
   logic             gnt_valid;

   function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
      int s;
      s = int'({{(32-SRC_W){1'b0}}, base}) + off;
      if (s >= N_MON) s = s - N_MON;
      return SRC_W'(s);
   endfunction

   always_comb begin
      for (int i = 0; i < N_MON; i++) begin
         mon_word[i] = mon_data_out[36*i +: 36];
         mon_cnt[i]  = mon_data_count[11*i +: 11];
      end
   end

   // Walk from the highest offset down so the monitor nearest ptr_q wins.
   always_comb begin
      scan_hit = 1'b0;
      scan_idx = '0;
      for (int k = N_MON - 1; k >= 0; k--) begin
         if (mon_cnt[wrap_add(ptr_q, k)] != 11'd0) begin
            scan_hit = 1'b1;
            scan_idx = wrap_add(ptr_q, k);
         end
      end
   end

   assign next_ptr  = wrap_add(grant_q, 1);
   assign gnt_word  = mon_word[grant_q];
   assign gnt_count = mon_cnt[grant_q];
   assign gnt_valid = mon_data_valid[grant_q];

   always_comb begin
      mon_data_read = '0;
      if (state_q == RD) mon_data_read[grant_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         ptr_q           <= '0;
         grant_q         <= '0;
         burst_cnt_q     <= '0;
         tmo_q           <= '0;
         tdata_q         <= '0;
         tsrc_q          <= '0;
         tlast_q         <= 1'b0;
         tvalid_q        <= 1'b0;
         en_q            <= 1'b0;
         loss_any_q      <= 1'b0;
         err_underflow_q <= 1'b0;
         err_format_q    <= 1'b0;
         words_q         <= '0;
      end else begin
         en_q       <= drain_enable;
         loss_any_q <= |mon_data_loss;
         unique case (state_q)
            IDLE: begin
               if (drain_enable) state_q <= ARB;
            end
            ARB: begin
               if (!drain_enable) begin
                  state_q <= IDLE;
               end else if (scan_hit) begin
                  grant_q     <= scan_idx;
                  burst_cnt_q <= '0;
                  state_q     <= RD;
               end
            end
            RD: begin
               tmo_q   <= '0;
               state_q <= WAIT_V;
            end
            WAIT_V: begin
               if (gnt_valid) begin
                  tdata_q  <= gnt_word;
                  tsrc_q   <= grant_q;
                  tvalid_q <= 1'b1;
                  tlast_q  <= (burst_cnt_q == BC_W'(BURST_LEN - 1)) || (gnt_count == 11'd0);
                  if (gnt_word[35:32] != 4'b0001) err_format_q <= 1'b1;
                  state_q  <= HOLD;
               end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  err_underflow_q <= 1'b1;
                  ptr_q           <= next_ptr;
                  state_q         <= ARB;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            HOLD: begin
               // A word in flight is always delivered, even once drain_enable has dropped.
               if (tvalid_q && m_axis.tready) begin
                  tvalid_q    <= 1'b0;
                  words_q     <= words_q + 32'd1;
                  burst_cnt_q <= burst_cnt_q + 1'b1;
                  if (tlast_q) ptr_q <= next_ptr;
                  if (!drain_enable) state_q <= IDLE;
                  else if (tlast_q)  state_q <= ARB;
                  else               state_q <= RD;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Restart of the monitors on a fresh enable resets the drain status with them.
         if (drain_enable && !en_q) begin
            words_q         <= '0;
            err_underflow_q <= 1'b0;
            err_format_q    <= 1'b0;
         end
      end
   end

   assign m_axis.tdata   = tdata_q;
   assign m_axis.tsrc    = tsrc_q;
   assign m_axis.tlast   = tlast_q;
   assign m_axis.tvalid  = tvalid_q;
   assign loss_any       = loss_any_q;
   assign err_underflow  = err_underflow_q;
   assign err_format     = err_format_q;
   assign words_drained  = words_q;

endmodule

// File: tb/tb_sigmon_event_drain.sv
// Bench for sigmon_event_drain: FIFO responders per monitor, a round-robin/burst
// model of the expected word stream, and a per-cycle compare process.
module tb_sigmon_event_drain;

   localparam int N_MON     = 4;
   localparam int SRC_W     = 2;
   localparam int BURST_LEN = 16;
   localparam int TIMEOUT   = 4;

   typedef struct packed {
      logic [35:0]      data;
      logic [SRC_W-1:0] src;
      logic             last;
   } expT;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 drain_enable;
   logic [N_MON*36-1:0]  mon_data_out;
   logic [N_MON*11-1:0]  mon_data_count;
   logic [N_MON-1:0]     mon_data_valid;
   logic [N_MON-1:0]     mon_data_loss;
   logic [N_MON-1:0]     mon_data_read;
   logic                 loss_any;
   logic                 err_underflow;
   logic                 err_format;
   logic [31:0]          words_drained;

   sigmon_event_drain_if #(.SRC_W(SRC_W)) mAxis();

   sigmon_event_drain #(
      .N_MON(N_MON), .SRC_W(SRC_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .drain_enable(drain_enable),
      .mon_data_out(mon_data_out), .mon_data_count(mon_data_count),
      .mon_data_valid(mon_data_valid), .mon_data_loss(mon_data_loss),
      .mon_data_read(mon_data_read), .m_axis(mAxis),
      .loss_any(loss_any), .err_underflow(err_underflow), .err_format(err_format),
      .words_drained(words_drained)
   );

   always #5 clk = ~clk;

   int               compareCount = 0;
   int               mismatchCount = 0;
   int               cycleNo = 0;
   logic [35:0]      fifoMem [N_MON][64];
   int               head [N_MON];
   int               tail [N_MON];
   bit               stallValid [N_MON];
   bit               pending [N_MON];
   expT              expQ [$];
   int               readCycles [$];
   logic [N_MON-1:0] readMask [$];
   int               readTotal = 0;
   int               modelCnt = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cycleNo);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic en, input logic rdy, input logic [N_MON-1:0] loss);
      drain_enable  = en;
      mAxis.tready  = rdy;
      mon_data_loss = loss;
      tick();
   endtask

   task automatic pushWord(input int m, input logic [35:0] w);
      fifoMem[m][tail[m]] = w;
      tail[m]++;
   endtask

   task automatic resetDut();
      reset = 1'b1;
      drain_enable = 1'b0;
      mAxis.tready = 1'b1;
      mon_data_loss = '0;
      repeat (3) tick();
      checkOutput("rst_tvalid", 64'(mAxis.tvalid), 64'(0));
      checkOutput("rst_read", 64'(mon_data_read), 64'(0));
      checkOutput("rst_words", 64'(words_drained), 64'(0));
      checkOutput("rst_err_underflow", 64'(err_underflow), 64'(0));
      checkOutput("rst_err_format", 64'(err_format), 64'(0));
      checkOutput("rst_tdata", 64'(mAxis.tdata), 64'(0));
      for (int i = 0; i < N_MON; i++) begin
         head[i] = 0;
         tail[i] = 0;
         stallValid[i] = 1'b0;
         pending[i] = 1'b0;
      end
      expQ.delete();
      readCycles.delete();
      readMask.delete();
      readTotal = 0;
      reset = 1'b0;
      tick();
   endtask

   // Expected stream: visit monitors round-robin from 0, take up to BURST_LEN per visit.
   task automatic buildExpected();
      int rem [N_MON];
      int pos [N_MON];
      int p = 0;
      int found;
      int n;
      bit more = 1'b1;
      expT e;
      expQ.delete();
      for (int i = 0; i < N_MON; i++) begin
         rem[i] = tail[i] - head[i];
         pos[i] = head[i];
      end
      while (more) begin
         found = -1;
         for (int k = 0; k < N_MON; k++)
            if (found < 0 && rem[(p + k) % N_MON] > 0) found = (p + k) % N_MON;
         if (found < 0) begin
            more = 1'b0;
         end else begin
            n = (rem[found] < BURST_LEN) ? rem[found] : BURST_LEN;
            for (int j = 0; j < n; j++) begin
               e.data = fifoMem[found][pos[found] + j];
               e.src  = SRC_W'(found);
               e.last = (j == n - 1);
               expQ.push_back(e);
            end
            pos[found] += n;
            rem[found] -= n;
            p = (found + 1) % N_MON;
         end
      end
   endtask

   task automatic waitWords(input int n, input int budget);
      int c = 0;
      while (modelCnt < n && c < budget) begin
         tick();
         c++;
      end
      checkOutput("drain_budget", 64'(modelCnt >= n), 64'(1));
   endtask

   task automatic waitTvalid(input int budget);
      int c = 0;
      while (!mAxis.tvalid && c < budget) begin
         tick();
         c++;
      end
      checkOutput("tvalid_budget", 64'(mAxis.tvalid), 64'(1));
   endtask

   initial forever begin
      @(posedge clk);
      cycleNo++;
   end

   // Registered-valid FIFO: a read seen this cycle yields data and valid on the next.
   initial begin
      mon_data_out   = '0;
      mon_data_count = '0;
      mon_data_valid = '0;
      for (int i = 0; i < N_MON; i++) begin
         head[i] = 0; tail[i] = 0; stallValid[i] = 1'b0; pending[i] = 1'b0;
      end
      forever begin
         tick();
         for (int i = 0; i < N_MON; i++) begin
            if (pending[i]) begin
               mon_data_out[36*i +: 36] = fifoMem[i][head[i]];
               head[i]++;
               mon_data_valid[i] = 1'b1;
            end else begin
               mon_data_valid[i] = 1'b0;
            end
            pending[i] = mon_data_read[i] && !stallValid[i];
            mon_data_count[11*i +: 11] = 11'(tail[i] - head[i]);
         end
      end
   end

   initial begin
      bit               prevEn = 1'b0;
      bit               prevLoss = 1'b0;
      bit               fmtModel = 1'b0;
      bit               held = 1'b0;
      logic [35:0]      heldData = '0;
      logic [SRC_W-1:0] heldSrc = '0;
      logic             heldLast = 1'b0;
      expT              e;
      forever begin
         @(negedge clk);
         if (reset) begin
            modelCnt = 0; prevEn = 1'b0; prevLoss = 1'b0; fmtModel = 1'b0; held = 1'b0;
         end else begin
            checkOutput("words_drained", 64'(words_drained), 64'(modelCnt));
            checkOutput("loss_any", 64'(loss_any), 64'(prevLoss));
            checkOutput("read_onehot", 64'($onehot0(mon_data_read)), 64'(1));
            checkOutput("read_while_valid", 64'(mAxis.tvalid && (mon_data_read != '0)), 64'(0));
            if (mon_data_read != '0) begin
               readCycles.push_back(cycleNo);
               readMask.push_back(mon_data_read);
               readTotal++;
            end
            if (held && mAxis.tvalid) begin
               checkOutput("hold_tdata", 64'(mAxis.tdata), 64'(heldData));
               checkOutput("hold_tsrc", 64'(mAxis.tsrc), 64'(heldSrc));
               checkOutput("hold_tlast", 64'(mAxis.tlast), 64'(heldLast));
            end
            if (mAxis.tvalid && mAxis.tready) begin
               checkOutput("word_expected", 64'(expQ.size() != 0), 64'(1));
               if (expQ.size() != 0) begin
                  e = expQ.pop_front();
                  checkOutput("tdata", 64'(mAxis.tdata), 64'(e.data));
                  checkOutput("tsrc", 64'(mAxis.tsrc), 64'(e.src));
                  checkOutput("tlast", 64'(mAxis.tlast), 64'(e.last));
                  if (e.data[35:32] != 4'b0001) fmtModel = 1'b1;
               end
               checkOutput("err_format", 64'(err_format), 64'(fmtModel));
               modelCnt++;
            end
            held     = mAxis.tvalid && !mAxis.tready;
            heldData = mAxis.tdata;
            heldSrc  = mAxis.tsrc;
            heldLast = mAxis.tlast;
            if (drain_enable && !prevEn) begin
               modelCnt = 0;
               fmtModel = 1'b0;
            end
            prevEn   = drain_enable;
            prevLoss = |mon_data_loss;
         end
      end
   end

   initial begin
      int enCycle;
      int readsBefore;
      reset = 1'b1;
      drain_enable = 1'b0;
      mAxis.tready = 1'b1;
      mon_data_loss = '0;

      // Single monitor with three words.
      resetDut();
      for (int j = 0; j < 3; j++) pushWord(1, {4'b0001, 8'h01, 24'(j + 16'h100)});
      buildExpected();
      checkOutput("model_t1_size", 64'(expQ.size()), 64'(3));
      checkOutput("model_t1_last", 64'({expQ[0].last, expQ[1].last, expQ[2].last}), 64'(3'b001));
      enCycle = cycleNo;
      applyStimulus(1'b1, 1'b1, '0);
      waitWords(3, 60);
      repeat (3) tick();
      checkOutput("t1_words", 64'(words_drained), 64'(3));
      checkOutput("t1_reads", 64'(readTotal), 64'(3));
      if (readCycles.size() == 3) begin
         checkOutput("t1_first_read", 64'(readCycles[0] - enCycle), 64'(2));
         checkOutput("t1_gap1", 64'(readCycles[1] - readCycles[0]), 64'(3));
         checkOutput("t1_gap2", 64'(readCycles[2] - readCycles[1]), 64'(3));
         checkOutput("t1_mask", 64'({readMask[0], readMask[1], readMask[2]}), 64'(12'h222));
      end
      checkOutput("t1_expq_empty", 64'(expQ.size()), 64'(0));
      checkOutput("t1_err_underflow", 64'(err_underflow), 64'(0));

      // Burst limit and round-robin between mon0 (20) and mon2 (5).
      resetDut();
      for (int j = 0; j < 20; j++) pushWord(0, {4'b0001, 8'h00, 24'(j)});
      for (int j = 0; j < 5; j++)  pushWord(2, {4'b0001, 8'h02, 24'(j)});
      buildExpected();
      checkOutput("model_t2_size", 64'(expQ.size()), 64'(25));
      checkOutput("model_t2_w15", 64'({expQ[15].src, expQ[15].last, expQ[14].last}), 64'(3'b010));
      checkOutput("model_t2_w16", 64'({expQ[16].src, expQ[20].src, expQ[20].last}), 64'(5'b10101));
      checkOutput("model_t2_w21", 64'({expQ[21].src, expQ[21].data[23:0], expQ[24].last}), 64'({2'd0, 24'd16, 1'b1}));
      applyStimulus(1'b1, 1'b1, '0);
      waitWords(25, 400);
      repeat (3) tick();
      checkOutput("t2_words", 64'(words_drained), 64'(25));
      checkOutput("t2_expq_empty", 64'(expQ.size()), 64'(0));

      // Backpressure for 10 cycles.
      resetDut();
      for (int j = 0; j < 3; j++) pushWord(3, {4'b0001, 8'h03, 24'(j + 24'hABC00)});
      buildExpected();
      applyStimulus(1'b1, 1'b0, '0);
      waitTvalid(20);
      checkOutput("t3_tsrc", 64'(mAxis.tsrc), 64'(3));
      readsBefore = readTotal;
      repeat (10) tick();
      checkOutput("t3_no_reads", 64'(readTotal - readsBefore), 64'(0));
      checkOutput("t3_still_valid", 64'(mAxis.tvalid), 64'(1));
      mAxis.tready = 1'b1;
      waitWords(3, 60);
      repeat (2) tick();
      checkOutput("t3_expq_empty", 64'(expQ.size()), 64'(0));

      // Missing valid after a read.
      resetDut();
      pushWord(2, {4'b0001, 8'h02, 24'h1});
      pushWord(2, {4'b0001, 8'h02, 24'h2});
      stallValid[2] = 1'b1;
      applyStimulus(1'b1, 1'b1, '0);
      repeat (5) tick();
      checkOutput("t4_err_before", 64'(err_underflow), 64'(0));
      tick();
      checkOutput("t4_err_set", 64'(err_underflow), 64'(1));
      tick();
      checkOutput("t4_rearb_read", 64'(mon_data_read), 64'(4'b0100));
      applyStimulus(1'b0, 1'b1, '0);
      repeat (10) tick();
      checkOutput("t4_err_sticky", 64'(err_underflow), 64'(1));
      checkOutput("t4_no_word", 64'(words_drained), 64'(0));
      head[2] = tail[2];
      applyStimulus(1'b1, 1'b1, '0);
      checkOutput("t4_err_cleared", 64'(err_underflow), 64'(0));
      applyStimulus(1'b0, 1'b1, '0);

      // Enable dropped in WAIT_V, then reset while a word is held.
      resetDut();
      for (int j = 0; j < 3; j++) pushWord(0, {4'b0001, 8'h50, 24'(j)});
      buildExpected();
      applyStimulus(1'b1, 1'b1, '0);
      tick();
      checkOutput("t5_read", 64'(mon_data_read), 64'(4'b0001));
      tick();
      drain_enable = 1'b0;
      repeat (10) tick();
      checkOutput("t5_words", 64'(words_drained), 64'(1));
      checkOutput("t5_one_read", 64'(readTotal), 64'(1));
      checkOutput("t5_idle_tvalid", 64'(mAxis.tvalid), 64'(0));
      applyStimulus(1'b1, 1'b0, '0);
      waitTvalid(20);
      reset = 1'b1;
      tick();
      checkOutput("t5_rst_tvalid", 64'(mAxis.tvalid), 64'(0));
      checkOutput("t5_rst_read", 64'(mon_data_read), 64'(0));

      // Bad header and loss flag.
      resetDut();
      pushWord(1, {4'b0010, 8'h61, 24'h1});
      pushWord(1, {4'b0001, 8'h61, 24'h2});
      buildExpected();
      applyStimulus(1'b1, 1'b1, 4'b1000);
      waitWords(2, 60);
      tick();
      checkOutput("t6_err_format", 64'(err_format), 64'(1));
      checkOutput("t6_loss_any", 64'(loss_any), 64'(1));
      checkOutput("t6_err_underflow", 64'(err_underflow), 64'(0));
      applyStimulus(1'b1, 1'b1, '0);
      tick();
      checkOutput("t6_loss_clear", 64'(loss_any), 64'(0));
      checkOutput("t6_expq_empty", 64'(expQ.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no completion, required finish before 1 ms");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
